// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks on the FFT result-streaming path.
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity-mode encodings for the PARITY parameter
//   tx_state_t                    : transmitter FSM state, also exported for debug
//   clks_per_bit()                : clock cycles per serial bit (integer division);
//                                   the receiver will use the same rounding
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer. Counts clock cycles while enabled and pulses tick on the
// last cycle of every bit period, then wraps to 0.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, counter to 0
//   enable : count this cycle
//   clear  : force the counter to 0 (has priority over enable, suppresses tick)
//   tick   : high during the final cycle of a CLKS_PER_BIT-cycle bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with an input FIFO. Words enter over a valid/ready handshake,
// are queued, and are sent LSB-first as start / data / [parity] / stop bits.
//   clk        : clock
//   rst_n      : asynchronous active-low reset; aborts any frame, empties FIFO
//   s_data     : word to send (DATA_BITS wide)
//   s_valid    : s_data is valid
//   s_ready    : FIFO has room
//   txd        : serial line, idle high, driven from a flop
//   busy       : a frame is on the line or words are waiting
//   fifo_level : number of words stored
//   dbgState   : current transmitter FSM state
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready is !full and never depends on s_valid; s_valid while full is ignored
// and the stored words are untouched.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output tx_state_t                     dbgState
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(DATA_BITS);

    // Parameter legality is checked at elaboration.
    if (CLKS_PER_BIT < 2) begin : gBadBaud
        $error("uart_tx_fifo: CLK_FREQ / BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : gBadParity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStopBits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end

    // ---------------------------------------------------------------------
    // FIFO: circular buffer, pointers carry one wrap bit so that equal
    // addresses with different wrap bits mean full.
    // ---------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wrPtr;
    logic [AW:0]          rdPtr;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] headWord;

    assign empty      = (wrPtr == rdPtr);
    assign full       = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign s_ready    = !full;
    assign push       = s_valid && !full;
    assign fifo_level = wrPtr - rdPtr;
    assign headWord   = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Bit timer: held at 0 in IDLE so every frame starts on a clean period.
    // ---------------------------------------------------------------------
    tx_state_t state;
    logic      tick;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uBaud (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state != ST_IDLE),
        .clear  (state == ST_IDLE),
        .tick   (tick)
    );

    // ---------------------------------------------------------------------
    // Transmit FSM
    // ---------------------------------------------------------------------
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parityBit;
    logic [BCW-1:0]       bitCount;
    logic                 stopCount;
    logic                 lastStop;
    logic                 busyFrame;

    assign lastStop = (stopCount == 1'(STOP_BITS - 1));

    // A word leaves the FIFO either from IDLE or on the final stop tick, which
    // is what makes back-to-back frames gapless.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if (state == ST_STOP && tick && lastStop) begin
                pop = 1'b1;
            end
        end
    end

    function automatic logic parityOf(input logic [DATA_BITS-1:0] w);
        return (PARITY == PAR_ODD) ? ~(^w) : (^w);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            bitCount  <= '0;
            stopCount <= 1'b0;
            txd       <= 1'b1;
            busyFrame <= 1'b0;
        end else begin
            // txd and busyFrame follow the state one cycle late, so each line
            // bit is held for exactly one full bit period from its first edge.
            case (state)
                ST_START:  txd <= 1'b0;
                ST_DATA:   txd <= shiftReg[0];
                ST_PARITY: txd <= parityBit;
                default:   txd <= 1'b1;
            endcase
            busyFrame <= (state != ST_IDLE) || pop;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shiftReg  <= headWord;
                        parityBit <= parityOf(headWord);
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        bitCount <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shiftReg <= shiftReg >> 1;
                        if (bitCount == BCW'(DATA_BITS - 1)) begin
                            stopCount <= 1'b0;
                            state     <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bitCount <= bitCount + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        stopCount <= 1'b0;
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (lastStop) begin
                            if (pop) begin
                                shiftReg  <= headWord;
                                parityBit <= parityOf(headWord);
                                state     <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            stopCount <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busyFrame || !empty;
    assign dbgState = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Four transmitters share one clock and reset, each with a different serial
// format (8N1, 7E2, 7O2, 9N2), all at 4 clocks per bit with a 16-deep FIFO.
// Drivers push the expected line frame into a per-transmitter queue when a
// word is accepted; a per-transmitter monitor decodes the line and compares.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int NDUT = 4;
    localparam int CPB  = 8 / 2;
    localparam int CFG_DB  [NDUT] = '{8, 7, 7, 9};
    localparam int CFG_PAR [NDUT] = '{0, 1, 2, 0};
    localparam int CFG_SB  [NDUT] = '{1, 2, 2, 2};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- DUT signals ----------------
    logic [8:0] sData   [NDUT];
    logic       sValid  [NDUT];
    logic       sReady  [NDUT];
    logic       txdLine [NDUT];
    logic       busy    [NDUT];
    logic [4:0] level   [NDUT];
    tx_state_t  dbg     [NDUT];

    // ---------------- scoreboard ----------------
    logic [15:0] expQ [NDUT][$];
    int          startLog [NDUT][$];
    logic [15:0] lastFrame [NDUT];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: bit 0 is the start bit, bits go out in index order.
    function automatic logic [15:0] frameOf(input int idx, input logic [8:0] w);
        logic [15:0] f;
        int ones;
        int pos;
        f = '0;
        ones = 0;
        for (int i = 0; i < CFG_DB[idx]; i++) begin
            f[1 + i] = w[i];
            ones += int'(w[i]);
        end
        pos = 1 + CFG_DB[idx];
        if (CFG_PAR[idx] == 1) begin
            f[pos] = (ones % 2 == 1);
            pos++;
        end else if (CFG_PAR[idx] == 2) begin
            f[pos] = (ones % 2 == 0);
            pos++;
        end
        for (int i = 0; i < CFG_SB[idx]; i++) f[pos + i] = 1'b1;
        return f;
    endfunction

    // ---------------- DUTs and line monitors ----------------
    for (genvar gi = 0; gi < NDUT; gi++) begin : gDut
        localparam int DB   = CFG_DB[gi];
        localparam int FLEN = 1 + DB + ((CFG_PAR[gi] != 0) ? 1 : 0) + CFG_SB[gi];

        uart_tx_fifo #(
            .CLK_FREQ   (8),
            .BAUD       (2),
            .DATA_BITS  (DB),
            .PARITY     (CFG_PAR[gi]),
            .STOP_BITS  (CFG_SB[gi]),
            .FIFO_DEPTH (16)
        ) uDut (
            .clk        (clk),
            .rst_n      (rst_n),
            .s_data     (sData[gi][DB-1:0]),
            .s_valid    (sValid[gi]),
            .s_ready    (sReady[gi]),
            .txd        (txdLine[gi]),
            .busy       (busy[gi]),
            .fifo_level (level[gi]),
            .dbgState   (dbg[gi])
        );

        initial begin : monitor
            bit          inFrame;
            int          cyc;
            int          unstable;
            logic [15:0] got;
            logic [15:0] want;
            inFrame = 0;
            cyc = 0;
            unstable = 0;
            got = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    inFrame = 0;
                end else begin
                    if (!inFrame && txdLine[gi] === 1'b0) begin
                        inFrame = 1;
                        cyc = 0;
                        unstable = 0;
                        got = '0;
                        startLog[gi].push_back(cycle);
                    end
                    if (inFrame) begin
                        if (cyc % CPB == 0) got[cyc / CPB] = txdLine[gi];
                        else if (txdLine[gi] !== got[cyc / CPB]) unstable++;
                        if (cyc == FLEN * CPB - 1) begin
                            inFrame = 0;
                            lastFrame[gi] = got;
                            check($sformatf("dut%0d frame expected", gi),
                                  32'(expQ[gi].size() != 0), 32'd1);
                            if (expQ[gi].size() != 0) begin
                                want = expQ[gi].pop_front();
                                check($sformatf("dut%0d frame bits", gi), 32'(got), 32'(want));
                                check($sformatf("dut%0d bit stable", gi), unstable, 0);
                            end
                        end else begin
                            cyc++;
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (entered at a negedge) ----------------
    task automatic sendWord(input int idx, input logic [8:0] w, output int accEdge);
        int n;
        n = 0;
        sData[idx] = w;
        sValid[idx] = 1'b1;
        while (sReady[idx] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d accept", idx), 32'(sReady[idx]), 32'd1);
        accEdge = -1;
        if (sReady[idx] === 1'b1) begin
            accEdge = cycle + 1;
            expQ[idx].push_back(frameOf(idx, w));
        end
        @(negedge clk);
        sValid[idx] = 1'b0;
    endtask

    task automatic waitUntil(input int c);
        while (cycle < c) @(negedge clk);
    endtask

    task automatic waitIdle(input int idx, input int budget);
        int n;
        n = 0;
        while ((expQ[idx].size() != 0 || busy[idx] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d drained", idx), 32'(expQ[idx].size()), 32'd0);
        check($sformatf("dut%0d idle busy", idx), 32'(busy[idx]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int acc;
        int acc2;
        int s;
        int accepted;
        logic [8:0] w;

        for (int i = 0; i < NDUT; i++) begin
            sData[i] = '0;
            sValid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset values, held in reset and just after release.
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d reset txd", i), 32'(txdLine[i]), 32'd1);
            check($sformatf("dut%0d reset busy", i), 32'(busy[i]), 32'd0);
            check($sformatf("dut%0d reset ready", i), 32'(sReady[i]), 32'd1);
            check($sformatf("dut%0d reset level", i), 32'(level[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d idle state", i), 32'(dbg[i]), 32'(ST_IDLE));
            check($sformatf("dut%0d idle txd", i), 32'(txdLine[i]), 32'd1);
        end

        // 8N1 single word 0xA5
        check("s1 busy before accept", 32'(busy[0]), 32'd0);
        sendWord(0, 9'h0A5, acc);
        check("s1 busy after accept", 32'(busy[0]), 32'd1);
        waitUntil(acc + 1);
        check("s1 txd before start", 32'(txdLine[0]), 32'd1);
        waitUntil(acc + 2);
        check("s1 txd start edge", 32'(txdLine[0]), 32'd0);
        s = acc + 2;
        waitUntil(s + 39);
        check("s1 busy last stop cycle", 32'(busy[0]), 32'd1);
        waitUntil(s + 40);
        check("s1 busy cleared", 32'(busy[0]), 32'd0);
        check("s1 line sequence", 32'(lastFrame[0][9:0]), 32'b1101001010);
        check("s1 start cycle", startLog[0].size() > 0 ? startLog[0][0] : -1, s);

        // 7E2 and 7O2 with 0x55
        sendWord(1, 9'h055, acc);
        sendWord(2, 9'h055, acc2);
        waitUntil(acc + 45);
        check("s2 even busy last cycle", 32'(busy[1]), 32'd1);
        waitUntil(acc + 46);
        check("s2 even busy cleared", 32'(busy[1]), 32'd0);
        waitUntil(acc2 + 45);
        check("s2 odd busy last cycle", 32'(busy[2]), 32'd1);
        waitUntil(acc2 + 46);
        check("s2 odd busy cleared", 32'(busy[2]), 32'd0);
        check("s2 even parity bit", 32'(lastFrame[1][8]), 32'd0);
        check("s2 odd parity bit", 32'(lastFrame[2][8]), 32'd1);

        // 9N2 with 0x1FF
        sendWord(3, 9'h1FF, acc);
        waitUntil(acc + 49);
        check("s6 busy last cycle", 32'(busy[3]), 32'd1);
        waitUntil(acc + 50);
        check("s6 busy cleared", 32'(busy[3]), 32'd0);
        check("s6 line sequence", 32'(lastFrame[3][11:0]), 32'b111111111110);

        // Full FIFO: one frame on the line, then 17 back-to-back writes.
        startLog[0].delete();
        sendWord(0, 9'($urandom_range(0, 255)), acc);
        waitUntil(acc + 10);
        accepted = 0;
        for (int i = 0; i < 17; i++) begin
            w = 9'($urandom_range(0, 255));
            sData[0] = w;
            sValid[0] = 1'b1;
            if (sReady[0] === 1'b1) begin
                expQ[0].push_back(frameOf(0, w));
                accepted++;
            end
            @(negedge clk);
        end
        sValid[0] = 1'b0;
        check("s3 accepted words", accepted, 16);
        check("s3 ready when full", 32'(sReady[0]), 32'd0);
        check("s3 level when full", 32'(level[0]), 32'd16);
        waitIdle(0, 17 * 40 + 200);
        check("s3 frame count", startLog[0].size(), 17);
        for (int i = 1; i < 17 && i < startLog[0].size(); i++) begin
            check($sformatf("s3 gap %0d", i), startLog[0][i] - startLog[0][i-1], 40);
        end

        // Push on the same edge as the stop-to-start pop at level 3.
        startLog[0].delete();
        sendWord(0, 9'($urandom_range(0, 255)), acc);
        s = acc + 2;
        for (int i = 0; i < 3; i++) sendWord(0, 9'($urandom_range(0, 255)), acc2);
        waitUntil(s + 38);
        check("s4 level before", 32'(level[0]), 32'd3);
        w = 9'($urandom_range(0, 255));
        sData[0] = w;
        sValid[0] = 1'b1;
        check("s4 ready", 32'(sReady[0]), 32'd1);
        if (sReady[0] === 1'b1) expQ[0].push_back(frameOf(0, w));
        @(negedge clk);
        sValid[0] = 1'b0;
        check("s4 level after push+pop", 32'(level[0]), 32'd3);
        waitIdle(0, 6 * 40 + 100);
        check("s4 second start", startLog[0].size() > 1 ? startLog[0][1] : -1, s + 40);

        // Reset during data bit 3, then a fresh word.
        sendWord(0, 9'h0F0, acc);
        s = acc + 2;
        sendWord(0, 9'($urandom_range(0, 255)), acc2);
        sendWord(0, 9'($urandom_range(0, 255)), acc2);
        waitUntil(s + 17);
        check("s5 txd in data bit 3", 32'(txdLine[0]), 32'd0);
        check("s5 busy in frame", 32'(busy[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("s5 txd async reset", 32'(txdLine[0]), 32'd1);
        check("s5 busy async reset", 32'(busy[0]), 32'd0);
        check("s5 level async reset", 32'(level[0]), 32'd0);
        check("s5 ready async reset", 32'(sReady[0]), 32'd1);
        expQ[0].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        startLog[0].delete();
        repeat (20) @(negedge clk);
        check("s5 line idle after reset", 32'(txdLine[0]), 32'd1);
        check("s5 no stale frame", startLog[0].size(), 0);
        sendWord(0, 9'h00F, acc);
        waitUntil(acc + 1);
        check("s5 txd before start", 32'(txdLine[0]), 32'd1);
        waitUntil(acc + 2);
        check("s5 txd start edge", 32'(txdLine[0]), 32'd0);
        waitIdle(0, 200);
        check("s5 line sequence", 32'(lastFrame[0][9:0]), 32'b1000011110);
        check("s5 single frame", startLog[0].size(), 1);

        // Randomised traffic on every format.
        for (int i = 0; i < NDUT; i++) begin
            for (int k = 0; k < 8; k++) begin
                sendWord(i, 9'($urandom_range(0, (1 << CFG_DB[i]) - 1)), acc);
                repeat ($urandom_range(0, 50)) @(negedge clk);
            end
        end
        for (int i = 0; i < NDUT; i++) waitIdle(i, 16 * 48 + 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter for the FFT result-streaming path. It takes bytes, or words up to 9 bits, over a valid/ready handshake into an internal FIFO, then serialises them LSB-first onto `txd`. Data width, parity, stop-bit count, FIFO depth and baud rate are configurable. It replaces the fixed 8N2 transmitter wherever more than one word must be queued, or where the serial format differs from 8N2.

## Interface
- `CLK_FREQ`, 50000000, input clock frequency in Hz
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division), must be ≥ 2 (elaboration error otherwise)
- `DATA_BITS`, 8, payload bits per frame, legal range 5..9
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd; any other value is an elaboration error
- `STOP_BITS`, 1, legal values 1 or 2
- `FIFO_DEPTH`, 16, power of two, ≥ 2
- `clk` input 1: single clock domain
- `rst_n` input 1: reset, asynchronous and active-low
- `s_data` input DATA_BITS: word to send
- `s_valid` input 1: `s_data` is valid
- `s_ready` output 1: FIFO can accept a word (`!full`)
- `txd` output 1: serial line, idle high
- `busy` output 1: a frame is in progress, or the FIFO is non-empty
- `fifo_level` output $clog2(FIFO_DEPTH)+1: number of words currently stored

## Operation
- **Reset values:** `txd` = 1, `busy` = 0, `s_ready` = 1, `fifo_level` = 0. FSM goes to IDLE, FIFO pointers to 0, baud counter to 0.
- **Write rule:** a word is written on a rising edge where `s_valid & s_ready`. When full, `s_valid` is ignored and no data is lost or overwritten.
- **Simultaneous push and pop:** when the FIFO is non-empty, a push and a pop in the same cycle leave `fifo_level` unchanged. When the FIFO is full, `s_ready` = 0, so a push cannot happen in the same cycle as the pop. A write into an empty FIFO is popped no earlier than the following cycle.
- **FSM states:** IDLE → START → DATA → PARITY (skipped when `PARITY` = 0) → STOP → IDLE or START.
  - IDLE: if the FIFO is non-empty, pop into the shift register, compute the parity bit, clear the baud counter, go to START.
  - START: `txd` = 0 for one bit time.
  - DATA: `txd` = shift[0]; shift right on each bit tick; the bit counter counts DATA_BITS ticks.
  - PARITY: `txd` = parity bit. Even: XOR of the data bits. Odd: the inverse of that XOR.
  - STOP: `txd` = 1 for STOP_BITS bit times. On the final tick, if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- **Bit time:** exactly CLKS_PER_BIT cycles. The baud counter runs only outside IDLE and raises a tick when it reaches CLKS_PER_BIT−1, then wraps to 0.
- **Output register:** `txd` is driven from a flop; it never glitches.
- **Asynchronous reset mid-frame:** `txd` returns to 1 immediately, the FIFO contents are discarded, and no partial frame resumes.

## Timing
- **First-word latency:** if a word is accepted at edge k into an empty FIFO with the FSM in IDLE, the pop happens at edge k+1 and `txd` falls at edge k+2.
- **Frame length:** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Back-to-back frames:** no idle gap. The next start bit begins on the cycle after the last stop-bit cycle.
- **`busy`:** asserts the cycle after the first accept. It deasserts on the cycle `txd` has completed the final stop bit and the FIFO is empty.
- **`s_ready`:** combinational from the FIFO flags; it does not depend on `s_valid`.

## Structure
- **Shared package `uart_pkg`:**
  - parity-mode localparams `PAR_NONE` / `PAR_EVEN` / `PAR_ODD`
  - the FSM state enum `tx_state_t`
  - a `clks_per_bit(CLK_FREQ, BAUD)` function, to be reused by the future receiver
- **Sub-module `uart_baud_tick`:**
  - inputs: `clk`, `rst_n`, `enable`, `clear`
  - output: `tick`
  - parameter: CLKS_PER_BIT
- **FIFO:** inline circular buffer with one extra pointer bit that distinguishes full from empty.

## Test plan
All scenarios use CLK_FREQ = 8, BAUD = 2, so CLKS_PER_BIT = 4.
1. **8N1 single word:** write 0xA5 → `txd` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; `busy` clears 40 cycles after the start bit begins.
2. **7E2:** write 0x55 (7-bit) with PARITY = 1 → parity bit = 0, two stop bits, frame length 44 cycles. Same frame with PARITY = 2 → parity bit = 1.
3. **Full FIFO:** burst 17 writes with FIFO_DEPTH = 16 while the line is stalled mid-frame → `s_ready` drops after 16 accepts, the 17th word is not stored, all 16 words appear in order, no inter-frame gap.
4. **Simultaneous push and pop:** FIFO level 3, push on the same edge as the STOP→START pop → `fifo_level` stays at 3.
5. **Reset mid-frame:** assert `rst_n` low during the DATA bit 3 → `txd` = 1 and `busy` = 0 without waiting for a clock edge. After release, a new write of 0x0F transmits correctly with the 2-cycle latency.
6. **9-bit data, no parity, 2 stop bits:** write 0x1FF → 9 ones then 2 stop bits, frame length 48 cycles.
